// File: rtl/uart_v2_pkg.sv
// Shared types and address map for the second-generation UART CSR block.
// Register layouts are packed structs so decode reads in field names.
package uart_v2_pkg;

  typedef struct packed {
    logic       dlab;
    logic       brk;
    logic       sp;
    logic       eps;
    logic       pen;
    logic       stb;
    logic [1:0] wls;
  } lcr_t;

  typedef struct packed {
    logic [1:0] rx_trig;
    logic [1:0] rsvd;
    logic       dma;
    logic       tx_rst;
    logic       rx_rst;
    logic       en;
  } fcr_t;

  typedef struct packed {
    logic err;
    logic temt;
    logic thre;
    logic bi;
    logic fe;
    logic pe;
    logic oe;
    logic dr;
  } lsr_t;

  typedef struct packed {
    logic edssi;
    logic elsi;
    logic etbei;
    logic erbfi;
  } ier_t;

  typedef enum logic [3:0] {
    NONE = 4'b0001,
    LS   = 4'b0110,
    RDA  = 4'b0100,
    CTO  = 4'b1100,
    THRE = 4'b0010
  } iir_id_t;

  localparam logic [2:0] ADDR_RBR = 3'd0;
  localparam logic [2:0] ADDR_IER = 3'd1;
  localparam logic [2:0] ADDR_IIR = 3'd2;
  localparam logic [2:0] ADDR_LCR = 3'd3;
  localparam logic [2:0] ADDR_MCR = 3'd4;
  localparam logic [2:0] ADDR_LSR = 3'd5;
  localparam logic [2:0] ADDR_MSR = 3'd6;
  localparam logic [2:0] ADDR_SCR = 3'd7;

  // start + data + parity + stop bits of one frame
  function automatic logic [3:0] char_bits(input lcr_t l);
    return 4'd6 + {2'b00, l.wls} + {3'b000, l.pen} + (l.stb ? 4'd2 : 4'd1);
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Reload down-counter producing the 16x oversample tick.
// UART_FRAC_DIV_EN adds a 4-bit fractional accumulator that stretches periods.
module uart_baud_gen #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DIV_W-1:0] div,
  input  logic [3:0]       frac,
  input  logic             load,
  output logic             tick
);

  logic [DIV_W:0] cnt;
  logic [DIV_W:0] period;
  logic           expire;

  assign expire = (div != '0) && (cnt <= (DIV_W+1)'(1));

`ifdef UART_FRAC_DIV_EN
  logic [3:0] acc;
  logic [4:0] acc_sum;

  assign acc_sum = {1'b0, acc} + {1'b0, frac};
  // a carry out of the accumulator stretches the next period by one cycle
  assign period  = {1'b0, div} + (DIV_W+1)'(acc_sum[4]);

  always_ff @(posedge clk or posedge rst)
    if (rst)         acc <= '0;
    else if (load)   acc <= '0;
    else if (expire) acc <= acc_sum[3:0];
`else
  assign period = {1'b0, div} + (DIV_W+1)'(frac & 4'h0);
`endif

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (load) begin
      cnt  <= {1'b0, div};
      tick <= 1'b0;
    end else if (div == '0) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (expire) begin
      cnt  <= period;
      tick <= 1'b1;
    end else begin
      cnt  <= cnt - 1'b1;
      tick <= 1'b0;
    end

endmodule

// File: rtl/uart_csr_v2.sv
// UART control/status register file: bus decode, LSR/IIR, interrupts, RX timeout.
// Define UART_FRAC_DIV_EN to add the DLF fractional-divisor register at addr 2 (DLAB=1).
module uart_csr_v2
  import uart_v2_pkg::*;
#(
  parameter  int FIFO_DEPTH    = 16,
  parameter  int DIV_W         = 16,
  parameter  int TIMEOUT_CHARS = 4,
  localparam int CNT_W         = $clog2(FIFO_DEPTH+1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_i,
  input  logic             rd_i,
  input  logic [2:0]       addr_i,
  input  logic [7:0]       din_i,
  output logic [7:0]       dout_o,
  output logic             tx_push_o,
  output logic             rx_pop_o,
  input  logic [7:0]       rx_fifo_dout_i,
  input  logic [CNT_W-1:0] rx_fifo_count_i,
  input  logic             tx_fifo_empty_i,
  input  logic             tx_shift_empty_i,
  input  logic             rx_char_i,
  input  logic             rx_oe_i,
  input  logic             rx_pe_i,
  input  logic             rx_fe_i,
  input  logic             rx_bi_i,
  output logic             baud_tick_o,
  output logic             tx_rst_o,
  output logic             rx_rst_o,
  output logic [7:0]       lcr_o,
  output logic             irq_o
);

  localparam int TO_W = $clog2(TIMEOUT_CHARS*16*12+1);

  lcr_t           lcr;
  ier_t           ier;
  fcr_t           fcr_wr;
  lsr_t           lsr;
  iir_id_t        iir_id;
  logic           fcr_en;
  logic [1:0]     fcr_trig;
  logic [7:0]     scr, iir, rdata;
  logic [DIV_W-1:0] div;
  logic [3:0]     dlf;
  logic           div_load, dlab, dlf_sel;
  logic           wr_thr, wr_dll, wr_dlm, wr_ier, wr_fcr, wr_dlf, rd_lsr, rd_iir;
  logic           oe_s, pe_s, fe_s, bi_s, thre_pend, tx_empty_q;
  logic [CNT_W-1:0] trig;
  logic [TO_W-1:0]  to_cnt, to_limit;
  logic           to_flag, to_clr;

  assign dlab   = lcr.dlab;
  assign fcr_wr = din_i;
  assign lcr_o  = lcr;

`ifdef UART_FRAC_DIV_EN
  assign dlf_sel = dlab;
  always_ff @(posedge clk or posedge rst)
    if (rst)         dlf <= '0;
    else if (wr_dlf) dlf <= din_i[3:0];
`else
  assign dlf_sel = 1'b0;
  assign dlf     = '0;
`endif

  assign wr_thr    = wr_i && addr_i == ADDR_RBR && !dlab;
  assign wr_dll    = wr_i && addr_i == ADDR_RBR && dlab;
  assign wr_ier    = wr_i && addr_i == ADDR_IER && !dlab;
  assign wr_dlm    = wr_i && addr_i == ADDR_IER && dlab;
  assign wr_fcr    = wr_i && addr_i == ADDR_IIR && !dlf_sel;
  assign wr_dlf    = wr_i && addr_i == ADDR_IIR && dlf_sel;
  assign rd_lsr    = rd_i && addr_i == ADDR_LSR;
  assign rd_iir    = rd_i && addr_i == ADDR_IIR && !dlf_sel;
  assign tx_push_o = wr_thr;
  // pop even when empty; the FIFO ignores it and the read returns zero
  assign rx_pop_o  = rd_i && addr_i == ADDR_RBR && !dlab;

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      lcr      <= '0;
      ier      <= '0;
      fcr_en   <= 1'b0;
      fcr_trig <= '0;
      scr      <= '0;
      div      <= '0;
      div_load <= 1'b0;
      tx_rst_o <= 1'b0;
      rx_rst_o <= 1'b0;
    end else begin
      div_load <= wr_dll | wr_dlm | wr_dlf;
      tx_rst_o <= wr_fcr & fcr_wr.tx_rst;
      rx_rst_o <= wr_fcr & fcr_wr.rx_rst;
      if (wr_dll) div[7:0] <= din_i;
      if (wr_dlm) div[DIV_W-1:8] <= din_i[DIV_W-9:0];
      if (wr_ier) ier <= din_i[3:0];
      if (wr_fcr) begin
        fcr_en   <= fcr_wr.en;
        fcr_trig <= fcr_wr.rx_trig;
      end
      if (wr_i && addr_i == ADDR_LCR) lcr <= din_i;
      if (wr_i && addr_i == ADDR_SCR) scr <= din_i;
    end

  always_comb begin
    trig = CNT_W'(1);
    if (fcr_en)
      case (fcr_trig)
        2'd0:    trig = CNT_W'(1);
        2'd1:    trig = CNT_W'(FIFO_DEPTH/4);
        2'd2:    trig = CNT_W'(FIFO_DEPTH/2);
        default: trig = CNT_W'(FIFO_DEPTH-2);
      endcase
  end

  // a pulse coincident with the LSR read survives the clear
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      {oe_s, pe_s, fe_s, bi_s} <= '0;
    end else if (rd_lsr) begin
      {oe_s, pe_s, fe_s, bi_s} <= {rx_oe_i, rx_pe_i, rx_fe_i, rx_bi_i};
    end else begin
      {oe_s, pe_s, fe_s, bi_s} <= {oe_s | rx_oe_i, pe_s | rx_pe_i, fe_s | rx_fe_i, bi_s | rx_bi_i};
    end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      thre_pend  <= 1'b0;
      tx_empty_q <= 1'b1;
    end else begin
      tx_empty_q <= tx_fifo_empty_i;
      if ((tx_fifo_empty_i && !tx_empty_q) || (wr_ier && din_i[1] && tx_fifo_empty_i))
        thre_pend <= 1'b1;
      else if (wr_thr || (rd_iir && iir_id == THRE))
        thre_pend <= 1'b0;
    end

  assign to_limit = TO_W'(TIMEOUT_CHARS*16) * TO_W'(char_bits(lcr));
  assign to_clr   = rx_char_i | rx_pop_o | (rx_fifo_count_i == '0) | rx_rst_o;

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      to_cnt  <= '0;
      to_flag <= 1'b0;
    end else if (to_clr) begin
      to_cnt  <= '0;
      to_flag <= 1'b0;
    end else if (baud_tick_o && to_cnt < to_limit) begin
      to_cnt <= to_cnt + 1'b1;
      if (to_cnt + 1'b1 == to_limit) to_flag <= 1'b1;
    end

  always_comb begin
    lsr      = '0;
    lsr.err  = pe_s | fe_s | bi_s;
    lsr.temt = tx_fifo_empty_i & tx_shift_empty_i;
    lsr.thre = tx_fifo_empty_i;
    lsr.bi   = bi_s;
    lsr.fe   = fe_s;
    lsr.pe   = pe_s;
    lsr.oe   = oe_s;
    lsr.dr   = rx_fifo_count_i != '0;
  end

  always_comb begin
    iir_id = NONE;
    if (ier.elsi && (oe_s | pe_s | fe_s | bi_s)) iir_id = LS;
    else if (ier.erbfi && rx_fifo_count_i >= trig) iir_id = RDA;
    else if (ier.erbfi && to_flag)                 iir_id = CTO;
    else if (ier.etbei && thre_pend)               iir_id = THRE;
  end

  assign iir = {fcr_en, fcr_en, 2'b00, iir_id};

  always_comb begin
    rdata = '0;
    case (addr_i)
      ADDR_RBR: rdata = dlab ? div[7:0] : (rx_fifo_count_i != '0 ? rx_fifo_dout_i : 8'h00);
      ADDR_IER: rdata = dlab ? 8'(div >> 8) : {4'h0, ier};
      ADDR_IIR: rdata = dlf_sel ? {4'h0, dlf} : iir;
      ADDR_LCR: rdata = lcr;
      ADDR_LSR: rdata = lsr;
      ADDR_SCR: rdata = scr;
      default:  rdata = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      dout_o <= '0;
      irq_o  <= 1'b0;
    end else begin
      if (rd_i) dout_o <= rdata;
      irq_o <= (iir_id != NONE);
    end

  uart_baud_gen #(.DIV_W(DIV_W)) u_baud (
    .clk  (clk),
    .rst  (rst),
    .div  (div),
    .frac (dlf),
    .load (div_load),
    .tick (baud_tick_o)
  );

endmodule

// File: tb/tb_uart_csr_v2.sv
// Self-checking bench for uart_csr_v2: register table, randomized LSR/IIR/RBR
// traffic against a reference model, and directed multi-cycle sequences.
module tb_uart_csr_v2;

  localparam int FIFO_DEPTH = 16;
  localparam int CNT_W      = 5;

  logic             clk = 1'b0;
  logic             rst;
  logic             wr_i, rd_i;
  logic [2:0]       addr_i;
  logic [7:0]       din_i, dout_o;
  logic             tx_push_o, rx_pop_o;
  logic [7:0]       rx_fifo_dout_i;
  logic [CNT_W-1:0] rx_fifo_count_i;
  logic             tx_fifo_empty_i, tx_shift_empty_i, rx_char_i;
  logic             rx_oe_i, rx_pe_i, rx_fe_i, rx_bi_i;
  logic             baud_tick_o, tx_rst_o, rx_rst_o, irq_o;
  logic [7:0]       lcr_o;

  int checks = 0;
  int failures = 0;

  uart_csr_v2 dut (
    .clk(clk), .rst(rst), .wr_i(wr_i), .rd_i(rd_i), .addr_i(addr_i), .din_i(din_i),
    .dout_o(dout_o), .tx_push_o(tx_push_o), .rx_pop_o(rx_pop_o),
    .rx_fifo_dout_i(rx_fifo_dout_i), .rx_fifo_count_i(rx_fifo_count_i),
    .tx_fifo_empty_i(tx_fifo_empty_i), .tx_shift_empty_i(tx_shift_empty_i),
    .rx_char_i(rx_char_i), .rx_oe_i(rx_oe_i), .rx_pe_i(rx_pe_i), .rx_fe_i(rx_fe_i),
    .rx_bi_i(rx_bi_i), .baud_tick_o(baud_tick_o), .tx_rst_o(tx_rst_o),
    .rx_rst_o(rx_rst_o), .lcr_o(lcr_o), .irq_o(irq_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // all bus tasks start and end 1 time unit after a rising edge
  task automatic bus_wr(input logic [2:0] a, input logic [7:0] d);
    wr_i = 1'b1; addr_i = a; din_i = d;
    @(posedge clk); #1;
    wr_i = 1'b0;
  endtask

  task automatic bus_rd(input logic [2:0] a, output logic [7:0] d);
    rd_i = 1'b1; addr_i = a;
    @(posedge clk); #1;
    rd_i = 1'b0;
    d = dout_o;
  endtask

  task automatic rd_chk(input string name, input logic [2:0] a, input logic [7:0] exp);
    logic [7:0] d;
    bus_rd(a, d);
    check(name, d, exp);
  endtask

  task automatic wait_tick(output int n);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!baud_tick_o && n < 64);
  endtask

  typedef struct {
    bit         wr;
    logic [2:0] addr;
    logic [7:0] data;
    logic [7:0] exp;
  } vec_t;

  function automatic int trig_of(input logic [7:0] f);
    if (!f[0]) return 1;
    case (f[7:6])
      2'd0:    return 1;
      2'd1:    return FIFO_DEPTH/4;
      2'd2:    return FIFO_DEPTH/2;
      default: return FIFO_DEPTH-2;
    endcase
  endfunction

  initial begin
    vec_t       vecs[19];
    logic [7:0] d, f, exp_v, head;
    logic [3:0] sticky_m, pulses;
    logic       en_m, txe, tse;
    int         trig_m, op, cnt, n, total, nticks;
    int         iv[16];

    rst = 1'b1; wr_i = 0; rd_i = 0; addr_i = 0; din_i = 0;
    rx_fifo_dout_i = 0; rx_fifo_count_i = 0; tx_fifo_empty_i = 1; tx_shift_empty_i = 1;
    rx_char_i = 0; rx_oe_i = 0; rx_pe_i = 0; rx_fe_i = 0; rx_bi_i = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_dout", dout_o, 8'h00);
    check("rst_tick", baud_tick_o, 1'b0);
    check("rst_irq", irq_o, 1'b0);
    check("rst_fifo_rst", {tx_rst_o, rx_rst_o}, 2'b00);
    check("rst_lcr", lcr_o, 8'h00);
    rst = 1'b0;
    @(posedge clk); #1;

    // register map table
    vecs[0]  = '{0, 3'd2, 8'h00, 8'h01};
    vecs[1]  = '{0, 3'd5, 8'h00, 8'h60};
    vecs[2]  = '{0, 3'd3, 8'h00, 8'h00};
    vecs[3]  = '{0, 3'd7, 8'h00, 8'h00};
    vecs[4]  = '{0, 3'd1, 8'h00, 8'h00};
    vecs[5]  = '{1, 3'd7, 8'hA5, 8'hA5};
    vecs[6]  = '{1, 3'd3, 8'h1B, 8'h1B};
    vecs[7]  = '{1, 3'd4, 8'h13, 8'h00};
    vecs[8]  = '{0, 3'd6, 8'h00, 8'h00};
    vecs[9]  = '{1, 3'd1, 8'hFC, 8'h0C};
    vecs[10] = '{1, 3'd3, 8'h83, 8'h83};
    vecs[11] = '{1, 3'd0, 8'h34, 8'h34};
    vecs[12] = '{1, 3'd1, 8'h12, 8'h12};
    vecs[13] = '{1, 3'd0, 8'h00, 8'h00};
    vecs[14] = '{1, 3'd1, 8'h00, 8'h00};
    vecs[15] = '{1, 3'd3, 8'h03, 8'h03};
    vecs[16] = '{0, 3'd1, 8'h00, 8'h0C};
    vecs[17] = '{1, 3'd1, 8'h00, 8'h00};
    vecs[18] = '{0, 3'd0, 8'h00, 8'h00};
    for (int i = 0; i < 19; i++) begin
      if (vecs[i].wr) bus_wr(vecs[i].addr, vecs[i].data);
      bus_rd(vecs[i].addr, d);
      check($sformatf("table[%0d]", i), d, vecs[i].exp);
    end

    // randomized LSR/IIR/RBR traffic; divisor is 0 so no timeout can fire
    bus_wr(3'd1, 8'h05);
    bus_wr(3'd2, 8'h00);
    en_m = 1'b0; trig_m = 1; sticky_m = '0;
    for (int i = 0; i < 300; i++) begin
      op     = (i % 16 == 0) ? 4 : int'($urandom_range(0, 3));
      pulses = (op != 4 && $urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
      cnt    = int'($urandom_range(0, FIFO_DEPTH));
      head   = 8'($urandom);
      txe    = 1'($urandom);
      tse    = 1'($urandom);
      f      = 8'($urandom);
      rx_fifo_count_i = CNT_W'(cnt); rx_fifo_dout_i = head;
      tx_fifo_empty_i = txe; tx_shift_empty_i = tse;
      {rx_bi_i, rx_fe_i, rx_pe_i, rx_oe_i} = pulses;
      exp_v = 8'h00;
      case (op)
        0: begin
          rd_i = 1; addr_i = 3'd5;
          exp_v = {|sticky_m[3:1], txe & tse, txe, sticky_m, cnt != 0};
        end
        1: begin
          rd_i = 1; addr_i = 3'd0;
          exp_v = (cnt != 0) ? head : 8'h00;
        end
        2: begin
          rd_i = 1; addr_i = 3'd2;
          exp_v = {en_m, en_m, 2'b00,
                   (sticky_m != 0) ? 4'b0110 : (cnt >= trig_m) ? 4'b0100 : 4'b0001};
        end
        4: begin
          wr_i = 1; addr_i = 3'd2; din_i = f;
        end
        default: ;
      endcase
      @(posedge clk); #1;
      rd_i = 0; wr_i = 0;
      {rx_bi_i, rx_fe_i, rx_pe_i, rx_oe_i} = 4'h0;
      if (op < 3) check($sformatf("rand[%0d] op%0d", i, op), dout_o, exp_v);
      sticky_m = (op == 0) ? pulses : (sticky_m | pulses);
      if (op == 4) begin
        en_m = f[0];
        trig_m = trig_of(f);
      end
    end
    tx_fifo_empty_i = 1; tx_shift_empty_i = 1; rx_fifo_count_i = 0;
    bus_rd(3'd5, d);

    // baud generator: divisor 4, then divisor 0
    bus_wr(3'd3, 8'h80);
    bus_wr(3'd1, 8'h00);
    bus_wr(3'd0, 8'h04);
    wait_tick(n);
    check("baud_first_tick_seen", n < 64, 1'b1);
    for (int i = 0; i < 3; i++) begin
      wait_tick(n);
      check($sformatf("baud_div4_interval[%0d]", i), n, 4);
    end
    bus_wr(3'd0, 8'h00);
    repeat (2) @(posedge clk);
    #1;
    nticks = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (baud_tick_o) nticks++;
    end
    check("baud_div0_no_ticks", nticks, 0);
    bus_wr(3'd3, 8'h03);

    // FIFO reset pulses
    bus_wr(3'd2, 8'h06);
    check("fcr_rst_pulse_hi", {tx_rst_o, rx_rst_o}, 2'b11);
    @(posedge clk); #1;
    check("fcr_rst_pulse_lo", {tx_rst_o, rx_rst_o}, 2'b00);

    // RX trigger level 14
    bus_wr(3'd1, 8'h01);
    bus_wr(3'd2, 8'hC1);
    rx_fifo_count_i = 13;
    rd_chk("trig_below_iir", 3'd2, 8'hC1);
    rx_fifo_count_i = 14; rx_fifo_dout_i = 8'h5A;
    @(negedge clk);
    check("trig_irq_lag", irq_o, 1'b0);
    @(posedge clk); #1;
    check("trig_irq_rise", irq_o, 1'b1);
    rd_chk("trig_iir_rda", 3'd2, 8'hC4);
    rd_i = 1; addr_i = 3'd0;
    @(negedge clk);
    check("rbr_pop", rx_pop_o, 1'b1);
    @(posedge clk); #1;
    rd_i = 0;
    check("rbr_dout", dout_o, 8'h5A);

    // line status priority and sticky clear
    bus_wr(3'd1, 8'h05);
    rx_pe_i = 1;
    @(posedge clk); #1;
    rx_pe_i = 0;
    rd_chk("ls_iir", 3'd2, 8'hC6);
    rd_chk("ls_lsr_pe", 3'd5, 8'hE5);
    rd_chk("ls_iir_after_clear", 3'd2, 8'hC4);
    rx_pe_i = 1; rd_i = 1; addr_i = 3'd5;
    @(posedge clk); #1;
    rd_i = 0; rx_pe_i = 0;
    check("ls_coincident_read", dout_o, 8'h61);
    rd_chk("ls_coincident_kept", 3'd5, 8'hE5);
    rd_chk("ls_cleared_again", 3'd5, 8'h61);

    // THRE interrupt
    bus_wr(3'd2, 8'h00);
    bus_wr(3'd1, 8'h02);
    @(posedge clk); #1;
    check("thre_irq", irq_o, 1'b1);
    rd_chk("thre_iir", 3'd2, 8'h02);
    rd_chk("thre_iir_cleared", 3'd2, 8'h01);
    @(posedge clk); #1;
    check("thre_irq_fall", irq_o, 1'b0);
    wr_i = 1; addr_i = 3'd0; din_i = 8'h55;
    @(negedge clk);
    check("thr_push", tx_push_o, 1'b1);
    @(posedge clk); #1;
    wr_i = 0; tx_fifo_empty_i = 0;
    repeat (3) @(posedge clk);
    #1;
    tx_fifo_empty_i = 1;
    repeat (2) @(posedge clk);
    #1;
    rd_chk("thre_iir_edge", 3'd2, 8'h02);

    // character timeout: 8N1 = 10 bits, 4 chars * 16 ticks * 10 = 640 ticks
    rx_fifo_count_i = 0;
    bus_wr(3'd3, 8'h83);
    bus_wr(3'd0, 8'h01);
    bus_wr(3'd3, 8'h03);
    bus_wr(3'd2, 8'h41);
    bus_wr(3'd1, 8'h01);
    rx_fifo_count_i = 1;
    repeat (630) @(posedge clk);
    #1;
    check("cto_not_early", irq_o, 1'b0);
    n = 0;
    while (!irq_o && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    total = 630 + n;
    check("cto_delay_640", (total >= 640 && total <= 643), 1'b1);
    rd_chk("cto_iir", 3'd2, 8'hCC);
    rx_char_i = 1;
    @(posedge clk); #1;
    rx_char_i = 0;
    rd_chk("cto_cleared_iir", 3'd2, 8'hC1);
    repeat (300) @(posedge clk);
    #1;
    check("cto_restarted", irq_o, 1'b0);

    // fractional divisor / addr 2 with DLAB set
    rx_fifo_count_i = 0;
    bus_wr(3'd3, 8'h80);
    bus_wr(3'd0, 8'h04);
    bus_wr(3'd1, 8'h00);
`ifdef UART_FRAC_DIV_EN
    bus_wr(3'd2, 8'h08);
    rd_chk("dlf_read", 3'd2, 8'h08);
    wait_tick(n);
    total = 0;
    for (int i = 0; i < 16; i++) begin
      wait_tick(iv[i]);
      total += iv[i];
    end
    check("frac_sum16", total, 16*4 + 8);
    for (int i = 0; i < 16; i++) begin
      check($sformatf("frac_iv_range[%0d]", i), (iv[i] == 4 || iv[i] == 5), 1'b1);
      if (i > 0) check($sformatf("frac_alternate[%0d]", i), (iv[i] != iv[i-1]), 1'b1);
    end
`else
    rd_chk("dlab_addr2_iir", 3'd2, 8'hC1);
    bus_wr(3'd2, 8'h00);
    rd_chk("dlab_addr2_fcr", 3'd2, 8'h01);
`endif

    // asynchronous reset in the middle of operation
    rx_fifo_count_i = 14;
    rx_pe_i = 1;
    @(posedge clk); #1;
    rx_pe_i = 0;
    @(posedge clk); #1;
    check("pre_rst_irq", irq_o, 1'b1);
    wait_tick(n);
    check("pre_rst_tick", baud_tick_o, 1'b1);
    rst = 1'b1;
    #1;
    check("async_rst_tick", baud_tick_o, 1'b0);
    check("async_rst_irq", irq_o, 1'b0);
    check("async_rst_dout", dout_o, 8'h00);
    rx_fifo_count_i = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    rd_chk("post_rst_lsr", 3'd5, 8'h60);
    rd_chk("post_rst_lcr", 3'd3, 8'h00);
    rd_chk("post_rst_iir", 3'd2, 8'h01);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
